// File: rtl/ball_engine.sv
// Per-frame Pong engine: ball motion, paddle/wall collision, scoring, win and game-over blink.
// All state advances on frame_tick; start acts immediately in IDLE/GAMEOVER; rst is asynchronous.
module ball_engine #(
    parameter int H_ACT        = 640,
    parameter int V_ACT        = 480,
    parameter int BALL_W       = 8,
    parameter int BALL_H       = 8,
    parameter int PAD_W        = 10,
    parameter int PAD_H        = 48,
    parameter int X_PADA       = 16,
    parameter int X_PADB       = 614,
    parameter int STEP         = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int FLASH_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] y_padA,
    input  logic [9:0] y_padB,
    output logic [9:0] x_padA,
    output logic [9:0] x_padB,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [2:0] scrA,
    output logic [2:0] scrB,
    output logic       lossA,
    output logic       lossB,
    output logic       gmv_flash,
    output logic       game_over
);

    localparam logic [10:0] HA = 11'(H_ACT);
    localparam logic [10:0] VA = 11'(V_ACT);
    localparam logic [10:0] BW = 11'(BALL_W);
    localparam logic [10:0] BH = 11'(BALL_H);
    localparam logic [10:0] PW = 11'(PAD_W);
    localparam logic [10:0] PH = 11'(PAD_H);
    localparam logic [10:0] XA = 11'(X_PADA);
    localparam logic [10:0] XB = 11'(X_PADB);
    localparam logic [10:0] ST = 11'(STEP);
    localparam logic [9:0]  XC = 10'((H_ACT - BALL_W) / 2);
    localparam logic [9:0]  YC = 10'((V_ACT - BALL_H) / 2);
    localparam logic [2:0]  WIN3 = 3'(WIN_SCORE);
    localparam int CNT_MAX = (SERVE_FRAMES > FLASH_FRAMES) ? SERVE_FRAMES : FLASH_FRAMES;
    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAMEOVER} state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          dx_q, dx_d, dy_q, dy_d;   // dx 1 = right, dy 1 = down
    logic [2:0]    scr_a_q, scr_a_d, scr_b_q, scr_b_d;
    logic          loss_a_q, loss_a_d, loss_b_q, loss_b_d;
    logic          flash_q, flash_d, over_q, over_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [10:0] x11, y11, pa11, pb11;
    logic        ov_a, ov_b;
    logic [9:0]  nx, ny;
    logic        ndx, ndy, miss_l, miss_r;

    assign x11  = {1'b0, x_q};
    assign y11  = {1'b0, y_q};
    assign pa11 = {1'b0, y_padA};
    assign pb11 = {1'b0, y_padB};
    assign ov_a = (y11 + BH > pa11) && (y11 < pa11 + PH);
    assign ov_b = (y11 + BH > pb11) && (y11 < pb11 + PH);

    always_comb begin
        ny  = y_q;
        ndy = dy_q;
        if (dy_q) begin
            if (y11 + BH + ST >= VA) begin
                ny  = 10'(VA - BH);
                ndy = 1'b0;
            end else begin
                ny = 10'(y11 + ST);
            end
        end else if (y11 < ST) begin
            ny  = '0;
            ndy = 1'b1;
        end else begin
            ny = 10'(y11 - ST);
        end

        // Paddle face is tested before the miss so a ball grazing the edge still returns.
        nx     = x_q;
        ndx    = dx_q;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (!dx_q) begin
            if ((x11 >= XA + PW) && (x11 - ST <= XA + PW) && ov_a) begin
                nx  = 10'(XA + PW);
                ndx = 1'b1;
            end else if (x11 < ST) begin
                miss_l = 1'b1;
            end else begin
                nx = 10'(x11 - ST);
            end
        end else begin
            if ((x11 + BW <= XB) && (x11 + BW + ST >= XB) && ov_b) begin
                nx  = 10'(XB - BW);
                ndx = 1'b0;
            end else if (x11 + BW + ST > HA) begin
                miss_r = 1'b1;
            end else begin
                nx = 10'(x11 + ST);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        scr_a_d  = scr_a_q;
        scr_b_d  = scr_b_q;
        loss_a_d = loss_a_q;
        loss_b_d = loss_b_q;
        flash_d  = flash_q;
        over_d   = over_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (miss_r || miss_l) begin
                        if (miss_r) scr_a_d = scr_a_q + 3'd1;
                        else        scr_b_d = scr_b_q + 3'd1;
                        cnt_d = '0;
                        if ((miss_r && scr_a_q + 3'd1 == WIN3) || (miss_l && scr_b_q + 3'd1 == WIN3)) begin
                            state_d  = GAMEOVER;
                            loss_b_d = miss_r;
                            loss_a_d = miss_l;
                            over_d   = 1'b1;
                            flash_d  = 1'b0;
                        end else begin
                            state_d = SERVE;
                            x_d     = XC;
                            y_d     = YC;
                            dx_d    = miss_r;   // serve toward whoever conceded
                        end
                    end else begin
                        x_d  = nx;
                        y_d  = ny;
                        dx_d = ndx;
                        dy_d = ndy;
                    end
                end
            end
            GAMEOVER: begin
                if (start) begin
                    state_d  = SERVE;
                    x_d      = XC;
                    y_d      = YC;
                    scr_a_d  = '0;
                    scr_b_d  = '0;
                    loss_a_d = 1'b0;
                    loss_b_d = 1'b0;
                    flash_d  = 1'b0;
                    over_d   = 1'b0;
                    cnt_d    = '0;
                end else if (frame_tick) begin
                    if (cnt_q == FLASH_LAST) begin
                        flash_d = ~flash_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= XC;
            y_q      <= YC;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            scr_a_q  <= '0;
            scr_b_q  <= '0;
            loss_a_q <= 1'b0;
            loss_b_q <= 1'b0;
            flash_q  <= 1'b0;
            over_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            scr_a_q  <= scr_a_d;
            scr_b_q  <= scr_b_d;
            loss_a_q <= loss_a_d;
            loss_b_q <= loss_b_d;
            flash_q  <= flash_d;
            over_q   <= over_d;
            cnt_q    <= cnt_d;
        end
    end

    assign x_padA    = 10'(X_PADA);
    assign x_padB    = 10'(X_PADB);
    assign x_ball    = x_q;
    assign y_ball    = y_q;
    assign scrA      = scr_a_q;
    assign scrB      = scr_b_q;
    assign lossA     = loss_a_q;
    assign lossB     = loss_b_q;
    assign gmv_flash = flash_q;
    assign game_over = over_q;

endmodule
